// File: rtl/issue_queue_param.sv
// rtl/issue_queue_param.sv - parametrised reservation station with wakeup and oldest-first issue
// Entries wake on writeback broadcast; per-FU select uses an age matrix so slot reuse never reorders age.
module issue_queue_param #(
  parameter int DEPTH  = 16,
  parameter int NUM_FU = 3,
  parameter int NUM_WB = 2,
  parameter int DATA_W = 32,
  parameter int PTAG_W = 6,
  parameter int ROB_W  = 6,
  parameter int OP_W   = 4,
  localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [DATA_W-1:0]        disp_pc,
  input  logic [DATA_W-1:0]        disp_imm,
  input  logic [OP_W-1:0]          disp_op,
  input  logic [FU_W-1:0]          disp_fu,
  input  logic [PTAG_W-1:0]        disp_dest_tag,
  input  logic [ROB_W-1:0]         disp_rob,
  input  logic [PTAG_W-1:0]        disp_src1_tag,
  input  logic                     disp_src1_rdy,
  input  logic [DATA_W-1:0]        disp_src1_data,
  input  logic [PTAG_W-1:0]        disp_src2_tag,
  input  logic                     disp_src2_rdy,
  input  logic [DATA_W-1:0]        disp_src2_data,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*PTAG_W-1:0] wb_tag,
  input  logic [NUM_WB*DATA_W-1:0] wb_data,
  input  logic [NUM_FU-1:0]        fu_ready,
  output logic [NUM_FU-1:0]        iss_valid,
  output logic [NUM_FU*DATA_W-1:0] iss_pc,
  output logic [NUM_FU*DATA_W-1:0] iss_imm,
  output logic [NUM_FU*DATA_W-1:0] iss_src1_data,
  output logic [NUM_FU*DATA_W-1:0] iss_src2_data,
  output logic [NUM_FU*OP_W-1:0]   iss_op,
  output logic [NUM_FU*PTAG_W-1:0] iss_dest_tag,
  output logic [NUM_FU*ROB_W-1:0]  iss_rob,
  output logic [CNT_W-1:0]         count
);

  logic [DEPTH-1:0]  e_valid, e_s1_rdy, e_s2_rdy;
  logic [OP_W-1:0]   e_op      [DEPTH];
  logic [FU_W-1:0]   e_fu      [DEPTH];
  logic [PTAG_W-1:0] e_dest    [DEPTH];
  logic [ROB_W-1:0]  e_rob     [DEPTH];
  logic [DATA_W-1:0] e_pc      [DEPTH];
  logic [DATA_W-1:0] e_imm     [DEPTH];
  logic [PTAG_W-1:0] e_s1_tag  [DEPTH];
  logic [PTAG_W-1:0] e_s2_tag  [DEPTH];
  logic [DATA_W-1:0] e_s1_data [DEPTH];
  logic [DATA_W-1:0] e_s2_data [DEPTH];
  // e_age[i][j] set means entry j is older than entry i
  logic [DEPTH-1:0]  e_age     [DEPTH];

  logic [DATA_W:0]   s1_wb [DEPTH];
  logic [DATA_W:0]   s2_wb [DEPTH];
  logic [DATA_W:0]   d1_wb, d2_wb;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_en;
  logic [DEPTH-1:0]  elig [NUM_FU];
  logic [NUM_FU-1:0] sel_any;
  logic [IDX_W-1:0]  sel_idx [NUM_FU];
  logic [DEPTH-1:0]  iss_mask;
  logic [CNT_W-1:0]  n_iss;

  // Returns {hit, data}; the lowest matching port wins.
  function automatic logic [DATA_W:0] wb_lookup(input logic [PTAG_W-1:0] tag);
    logic [DATA_W:0] r;
    r = '0;
    for (int p = NUM_WB - 1; p >= 0; p--) begin
      if (wb_valid[p] && (wb_tag[p*PTAG_W +: PTAG_W] == tag))
        r = {1'b1, wb_data[p*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  assign disp_ready = (count != CNT_W'(DEPTH));
  assign wr_en      = disp_valid && disp_ready && (disp_op != '0) && !flush;

  always_comb begin
    wr_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!e_valid[i]) wr_idx = IDX_W'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      s1_wb[i] = wb_lookup(e_s1_tag[i]);
      s2_wb[i] = wb_lookup(e_s2_tag[i]);
    end
    d1_wb = wb_lookup(disp_src1_tag);
    d2_wb = wb_lookup(disp_src2_tag);
  end

  always_comb begin
    iss_mask = '0;
    n_iss    = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      sel_any[f] = 1'b0;
      sel_idx[f] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        elig[f][i] = e_valid[i] && e_s1_rdy[i] && e_s2_rdy[i] && fu_ready[f] &&
                     (e_fu[i] == FU_W'(f));
      end
      // Oldest eligible entry is the one with no eligible older peer.
      for (int i = 0; i < DEPTH; i++) begin
        if (elig[f][i] && !(|(elig[f] & e_age[i]))) begin
          sel_any[f] = 1'b1;
          sel_idx[f] = IDX_W'(i);
        end
      end
      if (sel_any[f]) begin
        iss_mask[sel_idx[f]] = 1'b1;
        n_iss = n_iss + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid       <= '0;
      e_s1_rdy      <= '0;
      e_s2_rdy      <= '0;
      for (int i = 0; i < DEPTH; i++) e_age[i] <= '0;
      count         <= '0;
      iss_valid     <= '0;
      iss_pc        <= '0;
      iss_imm       <= '0;
      iss_src1_data <= '0;
      iss_src2_data <= '0;
      iss_op        <= '0;
      iss_dest_tag  <= '0;
      iss_rob       <= '0;
    end else if (flush) begin
      e_valid   <= '0;
      iss_valid <= '0;
      count     <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (e_valid[i] && !e_s1_rdy[i] && s1_wb[i][DATA_W]) begin
          e_s1_rdy[i]  <= 1'b1;
          e_s1_data[i] <= s1_wb[i][DATA_W-1:0];
        end
        if (e_valid[i] && !e_s2_rdy[i] && s2_wb[i][DATA_W]) begin
          e_s2_rdy[i]  <= 1'b1;
          e_s2_data[i] <= s2_wb[i][DATA_W-1:0];
        end
        if (iss_mask[i]) e_valid[i] <= 1'b0;
      end

      for (int f = 0; f < NUM_FU; f++) begin
        iss_valid[f] <= sel_any[f];
        if (sel_any[f]) begin
          iss_pc[f*DATA_W +: DATA_W]        <= e_pc[sel_idx[f]];
          iss_imm[f*DATA_W +: DATA_W]       <= e_imm[sel_idx[f]];
          iss_src1_data[f*DATA_W +: DATA_W] <= e_s1_data[sel_idx[f]];
          iss_src2_data[f*DATA_W +: DATA_W] <= e_s2_data[sel_idx[f]];
          iss_op[f*OP_W +: OP_W]            <= e_op[sel_idx[f]];
          iss_dest_tag[f*PTAG_W +: PTAG_W]  <= e_dest[sel_idx[f]];
          iss_rob[f*ROB_W +: ROB_W]         <= e_rob[sel_idx[f]];
        end
      end

      if (wr_en) begin
        e_valid[wr_idx]   <= 1'b1;
        e_op[wr_idx]      <= disp_op;
        e_fu[wr_idx]      <= disp_fu;
        e_dest[wr_idx]    <= disp_dest_tag;
        e_rob[wr_idx]     <= disp_rob;
        e_pc[wr_idx]      <= disp_pc;
        e_imm[wr_idx]     <= disp_imm;
        e_s1_tag[wr_idx]  <= disp_src1_tag;
        e_s2_tag[wr_idx]  <= disp_src2_tag;
        e_s1_rdy[wr_idx]  <= disp_src1_rdy || d1_wb[DATA_W];
        e_s2_rdy[wr_idx]  <= disp_src2_rdy || d2_wb[DATA_W];
        e_s1_data[wr_idx] <= disp_src1_rdy ? disp_src1_data : d1_wb[DATA_W-1:0];
        e_s2_data[wr_idx] <= disp_src2_rdy ? disp_src2_data : d2_wb[DATA_W-1:0];
        // Stale column bits from the slot's previous occupant must not make peers look younger.
        for (int j = 0; j < DEPTH; j++) e_age[j][wr_idx] <= 1'b0;
        e_age[wr_idx] <= e_valid;
      end

      count <= count + CNT_W'(wr_en) - n_iss;
    end
  end

endmodule

// File: tb/tb_issue_queue_param.sv
// tb/tb_issue_queue_param.sv - vector, directed and randomized checks of issue_queue_param
// The reference model keeps entries in an age-ordered queue and applies issue, wakeup, then dispatch.
module tb_issue_queue_param;
  localparam int DEPTH  = 16;
  localparam int NUM_FU = 3;
  localparam int NUM_WB = 2;

  logic clk = 1'b0;
  logic rst, flush, disp_valid, disp_ready;
  logic [31:0] disp_pc, disp_imm, disp_src1_data, disp_src2_data;
  logic [3:0]  disp_op;
  logic [1:0]  disp_fu;
  logic [5:0]  disp_dest_tag, disp_rob, disp_src1_tag, disp_src2_tag;
  logic        disp_src1_rdy, disp_src2_rdy;
  logic [1:0]  wb_valid;
  logic [11:0] wb_tag;
  logic [63:0] wb_data;
  logic [2:0]  fu_ready;
  logic [2:0]  iss_valid;
  logic [95:0] iss_pc, iss_imm, iss_src1_data, iss_src2_data;
  logic [11:0] iss_op;
  logic [17:0] iss_dest_tag, iss_rob;
  logic [4:0]  count;

  always #5 clk = ~clk;

  issue_queue_param dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_pc(disp_pc), .disp_imm(disp_imm), .disp_op(disp_op), .disp_fu(disp_fu),
    .disp_dest_tag(disp_dest_tag), .disp_rob(disp_rob),
    .disp_src1_tag(disp_src1_tag), .disp_src1_rdy(disp_src1_rdy), .disp_src1_data(disp_src1_data),
    .disp_src2_tag(disp_src2_tag), .disp_src2_rdy(disp_src2_rdy), .disp_src2_data(disp_src2_data),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .fu_ready(fu_ready),
    .iss_valid(iss_valid), .iss_pc(iss_pc), .iss_imm(iss_imm),
    .iss_src1_data(iss_src1_data), .iss_src2_data(iss_src2_data),
    .iss_op(iss_op), .iss_dest_tag(iss_dest_tag), .iss_rob(iss_rob), .count(count)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [1:0]  fu;
    logic [5:0]  dest, rob;
    logic [31:0] pc, imm;
    logic [5:0]  t1, t2;
    logic        r1, r2;
    logic [31:0] d1, d2;
  } ent_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [1:0]  fu;
    logic [2:0]  fu_rdy;
    logic [31:0] d1, d2;
    logic [5:0]  rob;
    logic [2:0]  exp_iv;
    logic [4:0]  exp_cnt;
  } vec_t;

  ent_t mq[$];
  ent_t m_slot [NUM_FU];
  logic [2:0] m_iv;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] wb_find(input logic [5:0] tag);
    for (int p = 0; p < NUM_WB; p++)
      if (wb_valid[p] && wb_tag[p*6 +: 6] == tag) return {1'b1, wb_data[p*32 +: 32]};
    return 33'd0;
  endfunction

  task automatic model_step();
    logic [32:0] h;
    ent_t e;
    bit acc;
    if (rst) begin
      mq.delete();
      m_iv = '0;
      for (int f = 0; f < NUM_FU; f++) m_slot[f] = '0;
      return;
    end
    if (flush) begin
      mq.delete();
      m_iv = '0;
      return;
    end
    acc  = disp_valid && (disp_op != 0) && (mq.size() < DEPTH);
    m_iv = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      if (fu_ready[f]) begin
        for (int k = 0; k < mq.size(); k++) begin
          if (int'(mq[k].fu) == f && mq[k].r1 && mq[k].r2) begin
            m_slot[f] = mq[k];
            m_iv[f]   = 1'b1;
            mq.delete(k);
            break;
          end
        end
      end
    end
    for (int k = 0; k < mq.size(); k++) begin
      e = mq[k];
      if (!e.r1) begin h = wb_find(e.t1); if (h[32]) begin e.r1 = 1'b1; e.d1 = h[31:0]; end end
      if (!e.r2) begin h = wb_find(e.t2); if (h[32]) begin e.r2 = 1'b1; e.d2 = h[31:0]; end end
      mq[k] = e;
    end
    if (acc) begin
      e.op = disp_op; e.fu = disp_fu; e.dest = disp_dest_tag; e.rob = disp_rob;
      e.pc = disp_pc; e.imm = disp_imm; e.t1 = disp_src1_tag; e.t2 = disp_src2_tag;
      e.r1 = disp_src1_rdy; e.d1 = disp_src1_data;
      e.r2 = disp_src2_rdy; e.d2 = disp_src2_data;
      if (!e.r1) begin h = wb_find(e.t1); if (h[32]) begin e.r1 = 1'b1; e.d1 = h[31:0]; end end
      if (!e.r2) begin h = wb_find(e.t2); if (h[32]) begin e.r2 = 1'b1; e.d2 = h[31:0]; end end
      mq.push_back(e);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, " count"}, 64'(count), 64'(mq.size()));
    check({tag, " disp_ready"}, 64'(disp_ready), 64'(mq.size() != DEPTH));
    check({tag, " iss_valid"}, 64'(iss_valid), 64'(m_iv));
    for (int f = 0; f < NUM_FU; f++) begin
      check($sformatf("%s f%0d op", tag, f),   64'(iss_op[f*4 +: 4]),        64'(m_slot[f].op));
      check($sformatf("%s f%0d dest", tag, f), 64'(iss_dest_tag[f*6 +: 6]),  64'(m_slot[f].dest));
      check($sformatf("%s f%0d rob", tag, f),  64'(iss_rob[f*6 +: 6]),       64'(m_slot[f].rob));
      check($sformatf("%s f%0d pc", tag, f),   64'(iss_pc[f*32 +: 32]),      64'(m_slot[f].pc));
      check($sformatf("%s f%0d imm", tag, f),  64'(iss_imm[f*32 +: 32]),     64'(m_slot[f].imm));
      check($sformatf("%s f%0d s1", tag, f),   64'(iss_src1_data[f*32 +: 32]), 64'(m_slot[f].d1));
      check($sformatf("%s f%0d s2", tag, f),   64'(iss_src2_data[f*32 +: 32]), 64'(m_slot[f].d2));
    end
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    wb_valid   = '0;
    flush      = 1'b0;
  endtask

  task automatic disp(input logic [3:0] op, input logic [1:0] fu, input logic [5:0] rob,
                      input logic r1, input logic [5:0] t1, input logic [31:0] d1,
                      input logic r2, input logic [5:0] t2, input logic [31:0] d2);
    disp_valid = 1'b1; disp_op = op; disp_fu = fu; disp_rob = rob;
    disp_dest_tag = rob + 6'd1; disp_pc = 32'h100 + 32'(rob) * 4; disp_imm = ~d1;
    disp_src1_rdy = r1; disp_src1_tag = t1; disp_src1_data = d1;
    disp_src2_rdy = r2; disp_src2_tag = t2; disp_src2_data = d2;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [6];
    vt[0] = '{4'd1,  2'd0, 3'b111, 32'd5,        32'd7,        6'd3,  3'b001, 5'd0};
    vt[1] = '{4'd2,  2'd1, 3'b111, 32'h0000AAAA, 32'h00005555, 6'd10, 3'b010, 5'd0};
    vt[2] = '{4'd9,  2'd2, 3'b111, 32'hFFFFFFFF, 32'd0,        6'd63, 3'b100, 5'd0};
    vt[3] = '{4'd0,  2'd1, 3'b111, 32'd1,        32'd2,        6'd4,  3'b000, 5'd0};
    vt[4] = '{4'd3,  2'd2, 3'b011, 32'd11,       32'd12,       6'd5,  3'b000, 5'd1};
    vt[5] = '{4'd15, 2'd0, 3'b110, 32'h12345678, 32'h9ABCDEF0, 6'd6,  3'b000, 5'd1};

    rst = 1'b1; idle(); fu_ready = 3'b111;
    disp(4'd0, 2'd0, 6'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
    disp_valid = 1'b0;
    wb_tag = '0; wb_data = '0;
    step("reset");
    step("reset");
    check("reset count", 64'(count), 64'd0);
    check("reset disp_ready", 64'(disp_ready), 64'd1);
    check("reset iss_valid", 64'(iss_valid), 64'd0);
    check("reset iss_pc", 64'(iss_pc[31:0]), 64'd0);
    rst = 1'b0;

    // Single-instruction vectors: write edge, then issue edge.
    for (int v = 0; v < 6; v++) begin
      disp(vt[v].op, vt[v].fu, vt[v].rob, 1'b1, 6'd0, vt[v].d1, 1'b1, 6'd0, vt[v].d2);
      fu_ready = vt[v].fu_rdy;
      step("vec write");
      idle();
      step("vec issue");
      check($sformatf("vec%0d iss_valid", v), 64'(iss_valid), 64'(vt[v].exp_iv));
      check($sformatf("vec%0d count", v), 64'(count), 64'(vt[v].exp_cnt));
      if (vt[v].exp_iv != 3'b000) begin
        check($sformatf("vec%0d src1", v), 64'(iss_src1_data[vt[v].fu*32 +: 32]), 64'(vt[v].d1));
        check($sformatf("vec%0d src2", v), 64'(iss_src2_data[vt[v].fu*32 +: 32]), 64'(vt[v].d2));
        check($sformatf("vec%0d rob", v), 64'(iss_rob[vt[v].fu*6 +: 6]), 64'(vt[v].rob));
      end
      fu_ready = 3'b111;
      step("vec drain");
      step("vec drain");
    end

    // Wakeup: broadcast on port 1, issue two edges later.
    disp(4'd1, 2'd0, 6'd20, 1'b0, 6'd12, 32'd0, 1'b1, 6'd0, 32'd3);
    step("wake write");
    idle();
    step("wake wait");
    wb_valid = 2'b10; wb_tag = {6'd12, 6'd0}; wb_data = {32'h0000DEAD, 32'h0};
    step("wake edge");
    check("wake early iss", 64'(iss_valid), 64'd0);
    idle();
    step("wake issue");
    check("wake iss_valid", 64'(iss_valid), 64'b001);
    check("wake src1", 64'(iss_src1_data[31:0]), 64'h0000DEAD);

    // Fill to DEPTH with fu1 blocked, 17th refused, then drain in order.
    fu_ready = 3'b101;
    for (int k = 0; k < 16; k++) begin
      disp(4'd1, 2'd1, 6'(k), 1'b1, 6'd0, 32'(k), 1'b1, 6'd0, 32'(k + 100));
      step("fill");
    end
    check("full count", 64'(count), 64'd16);
    check("full disp_ready", 64'(disp_ready), 64'd0);
    disp(4'd1, 2'd1, 6'd16, 1'b1, 6'd0, 32'd16, 1'b1, 6'd0, 32'd116);
    step("fill drop");
    check("full drop count", 64'(count), 64'd16);
    idle();
    fu_ready = 3'b111;
    for (int k = 0; k < 16; k++) begin
      step("drain");
      check("drain iss_valid", 64'(iss_valid), 64'b010);
      check("drain rob", 64'(iss_rob[11:6]), 64'(k));
    end
    check("drain count", 64'(count), 64'd0);

    // Dispatch-time bypass; both ports match, port 0 wins.
    disp(4'd4, 2'd0, 6'd30, 1'b1, 6'd0, 32'd1, 1'b0, 6'd9, 32'd0);
    wb_valid = 2'b11; wb_tag = {6'd9, 6'd9}; wb_data = {32'h00005555, 32'h00001234};
    step("bypass write");
    idle();
    step("bypass issue");
    check("bypass iss_valid", 64'(iss_valid), 64'b001);
    check("bypass src2", 64'(iss_src2_data[31:0]), 64'h00001234);

    // Three FUs issue together; then flush with pending entries.
    fu_ready = 3'b000;
    for (int k = 0; k < 3; k++) begin
      disp(4'd1, 2'(k), 6'(40 + k), 1'b1, 6'd0, 32'(k), 1'b1, 6'd0, 32'd0);
      step("tri write");
    end
    idle();
    fu_ready = 3'b111;
    step("tri issue");
    check("tri iss_valid", 64'(iss_valid), 64'b111);
    fu_ready = 3'b000;
    for (int k = 0; k < 5; k++) begin
      disp(4'd2, 2'(k % 3), 6'(50 + k), 1'b1, 6'd0, 32'(k), 1'b1, 6'd0, 32'd0);
      step("flush fill");
    end
    check("flush pending", 64'(count), 64'd5);
    fu_ready = 3'b111; flush = 1'b1;
    disp(4'd2, 2'd0, 6'd60, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
    step("flush edge");
    check("flush count", 64'(count), 64'd0);
    check("flush iss_valid", 64'(iss_valid), 64'd0);
    idle();
    for (int k = 0; k < 3; k++) begin
      step("post flush");
      check("post flush iss_valid", 64'(iss_valid), 64'd0);
    end

    // Age order beats slot order after slot reuse.
    fu_ready = 3'b001;
    disp(4'd1, 2'd0, 6'd5, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
    step("age x");
    disp(4'd1, 2'd2, 6'd7, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
    step("age y");
    disp(4'd1, 2'd2, 6'd8, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
    step("age z");
    idle();
    fu_ready = 3'b100;
    step("age first");
    check("age first valid", 64'(iss_valid), 64'b100);
    check("age first rob", 64'(iss_rob[17:12]), 64'd7);
    step("age second");
    check("age second valid", 64'(iss_valid), 64'b100);
    check("age second rob", 64'(iss_rob[17:12]), 64'd8);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 499) == 0);
      flush      = ($urandom_range(0, 63) == 0);
      disp(4'($urandom_range(0, 15)), 2'($urandom_range(0, 2)), 6'($urandom),
           ($urandom_range(0, 2) == 0), 6'($urandom_range(0, 15)), $urandom,
           ($urandom_range(0, 2) == 0), 6'($urandom_range(0, 15)), $urandom);
      disp_valid = ($urandom_range(0, 9) < 7);
      wb_valid   = 2'($urandom);
      wb_tag     = {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))};
      wb_data    = {$urandom, $urandom};
      fu_ready   = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
